// File: rtl/prog_clock_divider.sv
`default_nettype none
// ============================================================================
// Module      : prog_clock_divider
// Description : Multi-channel run-time programmable clock divider. Each
//               channel divides fast_clock by its own divisor N and emits a
//               registered divided clock (low floor(N/2) cycles, high the
//               rest) plus a one-cycle tick strobe per period. A new divisor
//               is staged in a shadow register and only takes over at the
//               channel's period boundary, so outputs never glitch.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   CHANNELS    - number of independent channels (1..8)
//   WIDTH       - counter / divisor width, max divisor 2^WIDTH-1
//   DIV_DEFAULT - divisor loaded at reset (values below 2 become 2)
//   CH_W        - width of the channel-select port
// Ports:
//   fast_clock  in   source clock, rising-edge logic
//   rst         in   asynchronous active-low reset
//   align       in   phase-align all channels (PROG_CLOCK_DIVIDER_ALIGN_EN only)
//   enable      in   per-channel run enable
//   div_load    in   single-cycle divisor write strobe
//   div_ch      in   channel addressed by div_load
//   div_value   in   new divisor (0 and 1 become 2)
//   clk_out     out  divided clocks, registered
//   tick        out  one-cycle strobe while a channel's count is 0
//   pending     out  a loaded divisor is waiting for the period boundary
// Optional feature macro: PROG_CLOCK_DIVIDER_ALIGN_EN
// ============================================================================
module prog_clock_divider #(
    parameter int CHANNELS    = 2,
    parameter int WIDTH       = 24,
    parameter int DIV_DEFAULT = 8,
    parameter int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                fast_clock,
    input  logic                rst,
`ifdef PROG_CLOCK_DIVIDER_ALIGN_EN
    input  logic                align,
`endif
    input  logic [CHANNELS-1:0] enable,
    input  logic                div_load,
    input  logic [CH_W-1:0]     div_ch,
    input  logic [WIDTH-1:0]    div_value,
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] pending
);

    // Divisors of 0 or 1 cannot produce a clock, so they are raised to 2.
    localparam logic [WIDTH-1:0] c_DIV_RESET =
        (DIV_DEFAULT < 2) ? WIDTH'(2) : WIDTH'(DIV_DEFAULT);

    function automatic logic [WIDTH-1:0] f_clamp(input logic [WIDTH-1:0] v);
        return (v < WIDTH'(2)) ? WIDTH'(2) : v;
    endfunction

    logic             w_align;
    logic [WIDTH-1:0] w_load_val;

`ifdef PROG_CLOCK_DIVIDER_ALIGN_EN
    assign w_align = align;
`else
    assign w_align = 1'b0;
`endif

    assign w_load_val = f_clamp(div_value);

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        logic [WIDTH-1:0] r_count;
        logic [WIDTH-1:0] r_div;
        logic [WIDTH-1:0] r_shadow;
        logic             r_pending;
        logic             r_clk;
        logic             r_tick;

        logic             w_load_hit;
        logic             w_wrap;
        logic             w_apply;
        logic [WIDTH-1:0] w_next;
        logic [WIDTH-1:0] w_half;

        // Out-of-range div_ch matches no channel, so such writes vanish.
        assign w_load_hit = div_load && (div_ch == CH_W'(gi));
        assign w_wrap     = (r_count == (r_div - WIDTH'(1)));
        assign w_next     = w_wrap ? '0 : (r_count + WIDTH'(1));
        assign w_half     = r_div >> 1;
        // A load on the wrap edge wins over the apply: the fresh value must
        // not be skipped, so the old divisor runs one more period.
        assign w_apply    = enable[gi] && w_wrap && r_pending && !w_load_hit;

        always_ff @(posedge fast_clock or negedge rst) begin
            if (!rst) begin
                r_count   <= '0;
                r_div     <= c_DIV_RESET;
                r_shadow  <= c_DIV_RESET;
                r_pending <= 1'b0;
                r_clk     <= 1'b0;
                r_tick    <= 1'b0;
            end else if (w_align) begin
                // Restart in phase; a staged divisor takes effect now and a
                // same-edge load is staged on top of it for the next boundary.
                r_count <= '0;
                r_clk   <= 1'b0;
                r_tick  <= 1'b0;
                if (r_pending) begin
                    r_div <= r_shadow;
                end
                r_pending <= w_load_hit;
                if (w_load_hit) begin
                    r_shadow <= w_load_val;
                end
            end else begin
                if (enable[gi]) begin
                    r_count <= w_next;
                    // Comparing the next count keeps clk_out aligned with
                    // the count it is registered alongside.
                    r_clk   <= (w_next >= w_half);
                    r_tick  <= w_wrap;
                end else begin
                    r_tick  <= 1'b0;
                end

                if (w_load_hit) begin
                    r_shadow  <= w_load_val;
                    r_pending <= 1'b1;
                end else if (w_apply) begin
                    r_div     <= r_shadow;
                    r_pending <= 1'b0;
                end
            end
        end

        assign clk_out[gi] = r_clk;
        assign tick[gi]    = r_tick;
        assign pending[gi] = r_pending;
    end : g_ch

endmodule : prog_clock_divider
`default_nettype wire

// File: tb/tb_prog_clock_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_clock_divider
// Description : Directed self-checking bench for prog_clock_divider with
//               three channels, reset divisor 8. Expected clk_out/tick words
//               are derived from each channel's phase (count after the edge)
//               and its divisor N: clk = phase >= N/2, tick = phase == 0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_clock_divider;

    localparam int CHANNELS = 3;
    localparam int WIDTH    = 16;
    localparam int CH_W     = 2;

    logic                fast_clock;
    logic                rst;
    logic [CHANNELS-1:0] enable;
    logic                div_load;
    logic [CH_W-1:0]     div_ch;
    logic [WIDTH-1:0]    div_value;
    logic [CHANNELS-1:0] clk_out;
    logic [CHANNELS-1:0] tick;
    logic [CHANNELS-1:0] pending;
`ifdef PROG_CLOCK_DIVIDER_ALIGN_EN
    logic                align;
`endif

    int n_vec;
    int n_bad;

    prog_clock_divider #(
        .CHANNELS   (CHANNELS),
        .WIDTH      (WIDTH),
        .DIV_DEFAULT(8)
    ) dut (
        .fast_clock(fast_clock),
        .rst       (rst),
`ifdef PROG_CLOCK_DIVIDER_ALIGN_EN
        .align     (align),
`endif
        .enable    (enable),
        .div_load  (div_load),
        .div_ch    (div_ch),
        .div_value (div_value),
        .clk_out   (clk_out),
        .tick      (tick),
        .pending   (pending)
    );

    initial fast_clock = 1'b0;
    always #5 fast_clock = ~fast_clock;

    // Expected {clk_out[2:0], tick[2:0]} from per-channel phase and divisor.
    function automatic logic [5:0] ph_exp(input int p0, input int n0,
                                          input int p1, input int n1,
                                          input int p2, input int n2);
        logic [5:0] r;
        r[3] = ((p0 % n0) >= (n0 / 2));
        r[4] = ((p1 % n1) >= (n1 / 2));
        r[5] = ((p2 % n2) >= (n2 / 2));
        r[0] = ((p0 % n0) == 0);
        r[1] = ((p1 % n1) == 0);
        r[2] = ((p2 % n2) == 0);
        return r;
    endfunction

    task automatic step();
        @(posedge fast_clock);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        enable    = '0;
        div_load  = 1'b0;
        div_ch    = '0;
        div_value = '0;
`ifdef PROG_CLOCK_DIVIDER_ALIGN_EN
        align     = 1'b0;
`endif
        repeat (2) step();
        rst    = 1'b1;
        enable = '1;
    endtask

    task automatic set_load(input logic [CH_W-1:0] ch, input int val);
        div_load  = 1'b1;
        div_ch    = ch;
        div_value = WIDTH'(val);
    endtask

    task automatic test_reset();
        logic [5:0] e;
        do_reset();
        rst = 1'b0;
        #1;
        n_vec++;
        if ({clk_out, tick, pending} !== 9'b0) begin
            n_bad++;
            $display("FAIL reset_state: got %b expected %b", {clk_out, tick, pending}, 9'b0);
        end
        rst = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            e = ph_exp(k, 8, k, 8, k, 8);
            n_vec++;
            if ({clk_out, tick} !== e) begin
                n_bad++;
                $display("FAIL reset_period8 edge=%0d: got %b expected %b", k, {clk_out, tick}, e);
            end
        end
    endtask

    task automatic test_load_mid();
        logic [5:0] e;
        logic [2:0] ep;
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            if (k == 4) set_load(2'd0, 5);
            step();
            div_load = 1'b0;
            e  = ph_exp(k, 8, k, 8, k, 8);
            ep = (k >= 4 && k < 8) ? 3'b001 : 3'b000;
            n_vec++;
            if ({clk_out, tick, pending} !== {e, ep}) begin
                n_bad++;
                $display("FAIL load_mid_wait edge=%0d: got %b expected %b", k, {clk_out, tick, pending}, {e, ep});
            end
        end
        for (int j = 1; j <= 10; j++) begin
            step();
            e = ph_exp(j, 5, j, 8, j, 8);
            n_vec++;
            if ({clk_out, tick} !== e) begin
                n_bad++;
                $display("FAIL load_mid_period5 j=%0d: got %b expected %b", j, {clk_out, tick}, e);
            end
        end
    endtask

    task automatic test_clamp();
        logic [5:0] e;
        logic [2:0] ep;
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            if (k == 1) set_load(2'd0, 0);
            if (k == 2) set_load(2'd0, 1);
            if (k == 3) set_load(2'd3, 5);
            step();
            div_load = 1'b0;
            e  = ph_exp(k, 8, k, 8, k, 8);
            ep = (k < 8) ? 3'b001 : 3'b000;
            n_vec++;
            if ({clk_out, tick, pending} !== {e, ep}) begin
                n_bad++;
                $display("FAIL clamp_wait edge=%0d: got %b expected %b", k, {clk_out, tick, pending}, {e, ep});
            end
        end
        for (int j = 1; j <= 8; j++) begin
            step();
            e = ph_exp(j, 2, j, 8, j, 8);
            n_vec++;
            if ({clk_out, tick} !== e) begin
                n_bad++;
                $display("FAIL clamp_period2 j=%0d: got %b expected %b", j, {clk_out, tick}, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] e;
        logic [2:0] ep;
        do_reset();
        for (int k = 1; k <= 16; k++) begin
            if (k == 8) set_load(2'd1, 6);
            if (k == 9) set_load(2'd1, 10);
            step();
            div_load = 1'b0;
            e  = ph_exp(k, 8, k, 8, k, 8);
            ep = (k >= 8 && k < 16) ? 3'b010 : 3'b000;
            n_vec++;
            if ({clk_out, tick, pending} !== {e, ep}) begin
                n_bad++;
                $display("FAIL wrap_load_wait edge=%0d: got %b expected %b", k, {clk_out, tick, pending}, {e, ep});
            end
        end
        for (int j = 1; j <= 10; j++) begin
            step();
            e = ph_exp(j, 8, j, 10, j, 8);
            n_vec++;
            if ({clk_out, tick} !== e) begin
                n_bad++;
                $display("FAIL back_to_back_period10 j=%0d: got %b expected %b", j, {clk_out, tick}, e);
            end
        end
    endtask

    task automatic test_enable();
        logic [5:0] e;
        do_reset();
        for (int k = 1; k <= 5; k++) step();
        enable = 3'b110;
        for (int k = 1; k <= 7; k++) begin
            step();
            e = ph_exp(5, 8, 5 + k, 8, 5 + k, 8);
            n_vec++;
            if ({clk_out, tick} !== e) begin
                n_bad++;
                $display("FAIL enable_frozen k=%0d: got %b expected %b", k, {clk_out, tick}, e);
            end
        end
        enable = 3'b111;
        for (int m = 1; m <= 8; m++) begin
            step();
            e = ph_exp(5 + m, 8, 12 + m, 8, 12 + m, 8);
            n_vec++;
            if ({clk_out, tick} !== e) begin
                n_bad++;
                $display("FAIL enable_resume m=%0d: got %b expected %b", m, {clk_out, tick}, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [5:0] e;
        do_reset();
        for (int k = 1; k <= 11; k++) begin
            if (k == 1)  set_load(2'd2, 3);
            if (k == 11) set_load(2'd2, 5);
            step();
            div_load = 1'b0;
        end
        n_vec++;
        if (pending !== 3'b100) begin
            n_bad++;
            $display("FAIL reset_mid_pending: got %b expected %b", pending, 3'b100);
        end
        #2 rst = 1'b0;
        #1;
        n_vec++;
        if ({clk_out, tick, pending} !== 9'b0) begin
            n_bad++;
            $display("FAIL reset_mid_async: got %b expected %b", {clk_out, tick, pending}, 9'b0);
        end
        rst = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            e = ph_exp(k, 8, k, 8, k, 8);
            n_vec++;
            if ({clk_out, tick, pending} !== {e, 3'b000}) begin
                n_bad++;
                $display("FAIL reset_mid_default edge=%0d: got %b expected %b", k, {clk_out, tick, pending}, {e, 3'b000});
            end
        end
    endtask

`ifdef PROG_CLOCK_DIVIDER_ALIGN_EN
    task automatic test_align();
        logic [5:0] e;
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            if (k == 1) set_load(2'd0, 5);
            if (k == 5) enable = 3'b011;
            step();
            div_load = 1'b0;
        end
        align = 1'b1;
        step();
        align  = 1'b0;
        enable = 3'b111;
        n_vec++;
        if ({clk_out, tick, pending} !== 9'b0) begin
            n_bad++;
            $display("FAIL align_edge: got %b expected %b", {clk_out, tick, pending}, 9'b0);
        end
        for (int j = 1; j <= 10; j++) begin
            step();
            e = ph_exp(j, 5, j, 8, j, 8);
            n_vec++;
            if ({clk_out, tick} !== e) begin
                n_bad++;
                $display("FAIL align_restart j=%0d: got %b expected %b", j, {clk_out, tick}, e);
            end
        end
    endtask
`endif

    initial begin
        n_vec = 0;
        n_bad = 0;
        test_reset();
        test_load_mid();
        test_clamp();
        test_back_to_back();
        test_enable();
        test_reset_mid();
`ifdef PROG_CLOCK_DIVIDER_ALIGN_EN
        test_align();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_prog_clock_divider
`default_nettype wire
